// File: rtl/ttt_pkg.sv
// Shared definitions for the tic-tac-toe game controller: cell codes,
// status and FSM encodings, the winning-line table and small helpers.
package ttt_pkg;

  typedef enum logic [1:0] {
    CELL_EMPTY = 2'b00,
    CELL_X     = 2'b01,
    CELL_O     = 2'b10
  } cell_t;

  typedef enum logic [1:0] {
    STAT_PLAY  = 2'b00,
    STAT_CHECK = 2'b01,
    STAT_WIN   = 2'b10,
    STAT_DRAW  = 2'b11
  } status_t;

  typedef enum logic [1:0] {
    ST_PLAY    = 2'b00,
    ST_CHECK   = 2'b01,
    ST_RESOLVE = 2'b10,
    ST_DONE    = 2'b11
  } state_t;

  // Winning button after priority arbitration; only one acts per cycle.
  typedef enum logic [2:0] {
    BTN_NONE  = 3'd0,
    BTN_NEW   = 3'd1,
    BTN_PLACE = 3'd2,
    BTN_UP    = 3'd3,
    BTN_DOWN  = 3'd4,
    BTN_LEFT  = 3'd5,
    BTN_RIGHT = 3'd6
  } btn_t;

  localparam int NUM_LINES = 8;

  // Lines in evaluation order: rows 0-2, columns 0-2, main diagonal, anti-diagonal.
  localparam logic [3:0] LINE_CELLS [0:NUM_LINES-1][0:2] = '{
    '{4'd0, 4'd1, 4'd2},
    '{4'd3, 4'd4, 4'd5},
    '{4'd6, 4'd7, 4'd8},
    '{4'd0, 4'd3, 4'd6},
    '{4'd1, 4'd4, 4'd7},
    '{4'd2, 4'd5, 4'd8},
    '{4'd0, 4'd4, 4'd8},
    '{4'd2, 4'd4, 4'd6}
  };

  // Cursor step with wrap inside the current row or column.
  function automatic logic [3:0] move_cursor(input logic [3:0] idx, input btn_t btn);
    logic [3:0] r;
    r = idx;
    case (btn)
      BTN_UP:    r = (idx < 4'd3) ? idx + 4'd6 : idx - 4'd3;
      BTN_DOWN:  r = (idx > 4'd5) ? idx - 4'd6 : idx + 4'd3;
      BTN_LEFT:  r = (idx == 4'd0 || idx == 4'd3 || idx == 4'd6) ? idx + 4'd2 : idx - 4'd1;
      BTN_RIGHT: r = (idx == 4'd2 || idx == 4'd5 || idx == 4'd8) ? idx - 4'd2 : idx + 4'd1;
      default:   r = idx;
    endcase
    return r;
  endfunction

  // Read the 2-bit code of one cell from the packed board.
  function automatic logic [1:0] cell_at(input logic [17:0] b, input logic [3:0] idx);
    logic [1:0] r;
    r = CELL_EMPTY;
    for (int i = 0; i < 9; i++) begin
      if (4'(i) == idx) r = b[2*i +: 2];
    end
    return r;
  endfunction

  // True once every cell holds a mark.
  function automatic logic board_full(input logic [17:0] b);
    logic full;
    full = 1'b1;
    for (int i = 0; i < 9; i++) begin
      if (b[2*i +: 2] == CELL_EMPTY) full = 1'b0;
    end
    return full;
  endfunction

endpackage

// File: rtl/ttt_line_lut.sv
// Maps a 3-bit line index to its three cell indices and a 9-bit cell mask.
import ttt_pkg::*;

module ttt_line_lut (
  input  logic [2:0] line_idx,
  output logic [3:0] cell_a,
  output logic [3:0] cell_b,
  output logic [3:0] cell_c,
  output logic [8:0] line_mask
);

  // Pure table lookup plus mask construction from the three indices.
  always_comb begin
    cell_a    = LINE_CELLS[line_idx][0];
    cell_b    = LINE_CELLS[line_idx][1];
    cell_c    = LINE_CELLS[line_idx][2];
    line_mask = (9'b1 << cell_a) | (9'b1 << cell_b) | (9'b1 << cell_c);
  end

endmodule

// File: rtl/ttt_game_ctrl.sv
// Tic-tac-toe game controller: cursor handling, mark placement, a fixed
// 8-cycle line scan for a win, then resolution to win, draw or next turn.
import ttt_pkg::*;

module ttt_game_ctrl #(
  parameter int START_CELL = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        btn_place,
  input  logic        btn_new,
  output logic [17:0] board,
  output logic [8:0]  cursor,
  output logic        turn,
  output logic [1:0]  status,
  output logic [8:0]  win_mask
);

  localparam logic [3:0] START_IDX = 4'(START_CELL);

  state_t     state;
  state_t     state_next;
  btn_t       btn;
  logic [3:0] cursor_idx;
  logic [3:0] cursor_next;
  logic [2:0] line_cnt;
  logic       win_found;
  logic [8:0] found_mask;
  logic [3:0] cell_a;
  logic [3:0] cell_b;
  logic [3:0] cell_c;
  logic [8:0] line_mask;
  logic [1:0] mark;
  logic       place_ok;
  logic       line_hit;

  ttt_line_lut u_line_lut (
    .line_idx  (line_cnt),
    .cell_a    (cell_a),
    .cell_b    (cell_b),
    .cell_c    (cell_c),
    .line_mask (line_mask)
  );

  // The mark of the player to move is also the mark just placed while scanning.
  assign mark        = turn ? CELL_O : CELL_X;
  assign place_ok    = (state == ST_PLAY) && (btn == BTN_PLACE) &&
                       (cell_at(board, cursor_idx) == CELL_EMPTY);
  assign line_hit    = (cell_at(board, cell_a) == mark) &&
                       (cell_at(board, cell_b) == mark) &&
                       (cell_at(board, cell_c) == mark);
  assign cursor_next = move_cursor(cursor_idx, btn);

  // Fixed-priority arbitration so only one button acts per cycle.
  always_comb begin
    btn = BTN_NONE;
    if (btn_new)        btn = BTN_NEW;
    else if (btn_place) btn = BTN_PLACE;
    else if (btn_up)    btn = BTN_UP;
    else if (btn_down)  btn = BTN_DOWN;
    else if (btn_left)  btn = BTN_LEFT;
    else if (btn_right) btn = BTN_RIGHT;
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_PLAY;
    else       state <= state_next;
  end

  // Next-state logic; a new game overrides everything, even mid-scan.
  always_comb begin
    state_next = state;
    if (btn == BTN_NEW) begin
      state_next = ST_PLAY;
    end else begin
      case (state)
        ST_PLAY:    if (place_ok) state_next = ST_CHECK;
        ST_CHECK:   if (line_cnt == 3'd7) state_next = ST_RESOLVE;
        ST_RESOLVE: state_next = (win_found || board_full(board)) ? ST_DONE : ST_PLAY;
        ST_DONE:    state_next = ST_DONE;
        default:    state_next = ST_PLAY;
      endcase
    end
  end

  // Status decode; both scan states report busy.
  always_comb begin
    status = STAT_PLAY;
    case (state)
      ST_PLAY:    status = STAT_PLAY;
      ST_CHECK,
      ST_RESOLVE: status = STAT_CHECK;
      ST_DONE:    status = win_found ? STAT_WIN : STAT_DRAW;
      default:    status = STAT_PLAY;
    endcase
  end

  // Board, cursor, turn and scan bookkeeping; cursor one-hot is registered from the index.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      board      <= '0;
      cursor_idx <= START_IDX;
      cursor     <= 9'b1 << START_IDX;
      turn       <= 1'b0;
      line_cnt   <= '0;
      win_found  <= 1'b0;
      found_mask <= '0;
      win_mask   <= '0;
    end else if (btn == BTN_NEW) begin
      board      <= '0;
      cursor_idx <= START_IDX;
      cursor     <= 9'b1 << START_IDX;
      turn       <= 1'b0;
      line_cnt   <= '0;
      win_found  <= 1'b0;
      found_mask <= '0;
      win_mask   <= '0;
    end else begin
      case (state)
        ST_PLAY: begin
          if (place_ok) begin
            for (int i = 0; i < 9; i++) begin
              if (4'(i) == cursor_idx) board[2*i +: 2] <= mark;
            end
            line_cnt   <= '0;
            win_found  <= 1'b0;
            found_mask <= '0;
          end else begin
            cursor_idx <= cursor_next;
            cursor     <= 9'b1 << cursor_next;
          end
        end
        ST_CHECK: begin
          line_cnt <= line_cnt + 3'd1;
          if (line_hit && !win_found) begin
            win_found  <= 1'b1;
            found_mask <= line_mask;
          end
        end
        ST_RESOLVE: begin
          if (win_found)               win_mask <= found_mask;
          else if (!board_full(board)) turn     <= ~turn;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ttt_game_ctrl.sv
// Self-checking bench for ttt_game_ctrl: a game-rule model compared every
// cycle, plus directed scenarios with literal expected values.
module tb_ttt_game_ctrl;

  localparam int START_CELL = 4;

  localparam logic [5:0] P_NEW   = 6'b100000;
  localparam logic [5:0] P_PLACE = 6'b010000;
  localparam logic [5:0] P_UP    = 6'b001000;
  localparam logic [5:0] P_DOWN  = 6'b000100;
  localparam logic [5:0] P_LEFT  = 6'b000010;
  localparam logic [5:0] P_RIGHT = 6'b000001;

  logic        clk = 1'b0;
  logic        reset;
  logic        btn_up, btn_down, btn_left, btn_right, btn_place, btn_new;
  logic [17:0] board;
  logic [8:0]  cursor;
  logic        turn;
  logic [1:0]  status;
  logic [8:0]  win_mask;

  int err_count   = 0;
  int check_count = 0;
  bit compare_en  = 1'b0;

  ttt_game_ctrl #(.START_CELL(START_CELL)) dut (
    .clk       (clk),
    .reset     (reset),
    .btn_up    (btn_up),
    .btn_down  (btn_down),
    .btn_left  (btn_left),
    .btn_right (btn_right),
    .btn_place (btn_place),
    .btn_new   (btn_new),
    .board     (board),
    .cursor    (cursor),
    .turn      (turn),
    .status    (status),
    .win_mask  (win_mask)
  );

  always #5 clk = ~clk;

  // Game model: cells hold 0 empty, 1 X, 2 O; phase 0 play, 1 busy, 2 done.
  int m_cell [9];
  int m_row, m_col, m_turn, m_phase, m_busy, m_idx;
  bit m_win, m_full;
  logic [8:0] m_mask;
  int lines [8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                       '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};

  function automatic void model_clear();
    for (int i = 0; i < 9; i++) m_cell[i] = 0;
    m_row   = START_CELL / 3;
    m_col   = START_CELL % 3;
    m_turn  = 0;
    m_phase = 0;
    m_busy  = 0;
    m_win   = 1'b0;
    m_full  = 1'b0;
    m_mask  = '0;
  endfunction

  // Place a mark and decide the game outcome up front; it is revealed after the busy window.
  function automatic void model_place();
    m_idx = 3 * m_row + m_col;
    if (m_cell[m_idx] == 0) begin
      m_cell[m_idx] = m_turn + 1;
      m_phase = 1;
      m_busy  = 9;
      m_win   = 1'b0;
      m_mask  = '0;
      for (int l = 0; l < 8; l++) begin
        if (!m_win && m_cell[lines[l][0]] == m_turn + 1 &&
            m_cell[lines[l][1]] == m_turn + 1 && m_cell[lines[l][2]] == m_turn + 1) begin
          m_win  = 1'b1;
          m_mask = 9'((1 << lines[l][0]) | (1 << lines[l][1]) | (1 << lines[l][2]));
        end
      end
      m_full = 1'b1;
      for (int i = 0; i < 9; i++) if (m_cell[i] == 0) m_full = 1'b0;
    end
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      model_clear();
    end else if (btn_new) begin
      model_clear();
    end else if (m_phase == 0) begin
      if (btn_place)      model_place();
      else if (btn_up)    m_row = (m_row + 2) % 3;
      else if (btn_down)  m_row = (m_row + 1) % 3;
      else if (btn_left)  m_col = (m_col + 2) % 3;
      else if (btn_right) m_col = (m_col + 1) % 3;
    end else if (m_phase == 1) begin
      m_busy = m_busy - 1;
      if (m_busy == 0) begin
        if (m_win || m_full) m_phase = 2;
        else begin
          m_turn  = 1 - m_turn;
          m_phase = 0;
        end
      end
    end
  end

  function automatic logic [17:0] exp_board();
    logic [17:0] b;
    b = '0;
    for (int i = 0; i < 9; i++) b[2*i +: 2] = 2'(m_cell[i]);
    return b;
  endfunction

  function automatic logic [17:0] exp_status();
    if (m_phase == 0) return 18'd0;
    if (m_phase == 1) return 18'd1;
    return m_win ? 18'd2 : 18'd3;
  endfunction

  task automatic checkOutput(input string name, input logic [17:0] actual, input logic [17:0] expected);
    check_count++;
    if (actual !== expected) begin
      err_count++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Per-cycle comparison against the model, well away from the rising edge.
  always @(negedge clk) begin
    if (compare_en) begin
      checkOutput("board",    board,           exp_board());
      checkOutput("cursor",   18'(cursor),     18'(9'b1 << (3 * m_row + m_col)));
      checkOutput("turn",     18'(turn),       18'(m_turn));
      checkOutput("status",   18'(status),     exp_status());
      checkOutput("win_mask", 18'(win_mask),   (m_phase == 2 && m_win) ? 18'(m_mask) : 18'd0);
    end
  end

  // One-cycle button pulse; returns 2 time units after the sampling edge.
  task automatic applyStimulus(input logic [5:0] b);
    {btn_new, btn_place, btn_up, btn_down, btn_left, btn_right} = b;
    @(posedge clk);
    #2;
    {btn_new, btn_place, btn_up, btn_down, btn_left, btn_right} = 6'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic goto_cell(input int t);
    for (int k = 0; k < 3 && m_col != t % 3; k++) applyStimulus(P_RIGHT);
    for (int k = 0; k < 3 && m_row != t / 3; k++) applyStimulus(P_DOWN);
  endtask

  task automatic place_at(input int t);
    goto_cell(t);
    applyStimulus(P_PLACE);
    idle(9);
  endtask

  int draw_seq [9] = '{0, 1, 2, 4, 3, 5, 7, 6, 8};

  initial begin
    {btn_new, btn_place, btn_up, btn_down, btn_left, btn_right} = 6'b0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    compare_en = 1'b1;
    checkOutput("reset_cursor", 18'(cursor), 18'(9'b000010000));
    checkOutput("reset_board",  board,       18'h0);
    checkOutput("reset_status", 18'(status), 18'd0);
    reset = 1'b0;
    idle(1);

    // Cursor wrap checks
    applyStimulus(P_LEFT);
    checkOutput("left_from_4", 18'(cursor), 18'(9'b000001000));
    applyStimulus(P_UP);
    applyStimulus(P_RIGHT);
    checkOutput("at_cell_1", 18'(cursor), 18'(9'b000000010));
    applyStimulus(P_UP);
    checkOutput("up_wrap_1_to_7", 18'(cursor), 18'(9'b010000000));

    // X wins on the top row
    applyStimulus(P_NEW);
    checkOutput("new_cursor", 18'(cursor), 18'(9'b000010000));
    place_at(0);
    place_at(3);
    place_at(1);
    place_at(4);
    goto_cell(2);
    applyStimulus(P_PLACE);
    idle(8);
    checkOutput("still_busy_n9", 18'(status), 18'd1);
    idle(1);
    checkOutput("win_status",   18'(status),   18'd2);
    checkOutput("win_turn",     18'(turn),     18'd0);
    checkOutput("win_mask_row", 18'(win_mask), 18'(9'b000000111));
    checkOutput("win_board",    board,         18'h00295);
    applyStimulus(P_PLACE | P_LEFT);
    idle(2);

    // Placing over an occupied cell is ignored
    applyStimulus(P_NEW);
    place_at(4);
    applyStimulus(P_PLACE);
    checkOutput("occ_board",  board,         18'h00100);
    checkOutput("occ_turn",   18'(turn),     18'd1);
    checkOutput("occ_status", 18'(status),   18'd0);
    idle(2);

    // Full board without a line
    applyStimulus(P_NEW);
    for (int i = 0; i < 9; i++) place_at(draw_seq[i]);
    checkOutput("draw_status", 18'(status),   18'd3);
    checkOutput("draw_mask",   18'(win_mask), 18'd0);
    checkOutput("draw_turn",   18'(turn),     18'd0);

    // New game in the middle of the scan
    applyStimulus(P_NEW);
    applyStimulus(P_PLACE);
    idle(2);
    applyStimulus(P_NEW);
    checkOutput("midnew_board",  board,         18'h0);
    checkOutput("midnew_cursor", 18'(cursor),   18'(9'b000010000));
    checkOutput("midnew_status", 18'(status),   18'd0);

    // Place wins over a same-cycle move, then reset during the scan
    applyStimulus(P_PLACE | P_LEFT);
    checkOutput("pl_board",  board,        18'h00100);
    checkOutput("pl_cursor", 18'(cursor),  18'(9'b000010000));
    idle(1);
    reset = 1'b1;
    #1;
    checkOutput("rst_board",  board,         18'h0);
    checkOutput("rst_cursor", 18'(cursor),   18'(9'b000010000));
    checkOutput("rst_status", 18'(status),   18'd0);
    checkOutput("rst_mask",   18'(win_mask), 18'd0);
    @(posedge clk);
    #2;
    reset = 1'b0;
    idle(1);
    place_at(0);
    checkOutput("after_rst_board", board, 18'h00001);
    idle(2);

    compare_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", err_count, check_count);
    $finish;
  end

endmodule
